// File: rtl/prog_loader_mem.sv
// Program store for the 1-bit CPU core: loads over a valid/ready stream while holding the core in reset, then serves instructions.
// Optional parity check on the loaded program is enabled by defining LOADER_PARITY_EN.
module prog_loader_mem #(
    parameter int ADDR_W = 1,
    parameter int DATA_W = 1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    input  logic              ld_par,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              cpu_n_rst,
    output logic              loaded,
    output logic              par_err
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2,
        ERR     = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic              par_acc;
    logic              xfer;
    logic              full;
    logic              complete;
    logic              beat_par;
    logic              par_ok;

    function automatic logic parity_of(input logic [DATA_W-1:0] word);
        return ^word;
    endfunction

    assign ld_ready = (state == LOAD);
    assign xfer     = ld_valid && ld_ready;
    assign full     = (wr_ptr == ADDR_W'(DEPTH - 1));
    assign complete = xfer && (ld_last || full);
    assign beat_par = parity_of(ld_data);

`ifdef LOADER_PARITY_EN
    assign par_ok = ((par_acc ^ beat_par) == ld_par);
`else
    logic unused_par;
    assign par_ok     = 1'b1;
    assign unused_par = ld_par;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            LOAD:    if (complete) state_next = par_ok ? RELEASE : ERR;
            RELEASE: state_next = RUN;
            RUN:     state_next = RUN;
            ERR:     state_next = ERR;
            default: state_next = LOAD;
        endcase
    end

    // Load datapath; the pointer saturates at the last entry so a full buffer never wraps.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr  <= '0;
            par_acc <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (xfer) begin
            mem[wr_ptr] <= ld_data;
            par_acc     <= par_acc ^ beat_par;
            if (!full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cpu_n_rst <= 1'b0;
            loaded    <= 1'b0;
        end else begin
            cpu_n_rst <= (state_next == RUN);
            loaded    <= (state_next == RUN);
        end
    end

`ifdef LOADER_PARITY_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            par_err <= 1'b0;
        end else begin
            par_err <= (state_next == ERR);
        end
    end
`else
    assign par_err = 1'b0;
`endif

    assign data = (state == RUN) ? mem[addr] : '0;

endmodule

// File: tb/tb_prog_loader_mem.sv
// Directed bench for prog_loader_mem: reset state, load/release timing, buffer-full completion, mid-load reset, parity option.
module tb_prog_loader_mem;

    logic clk;
    logic n_rst;
    logic ld_valid;
    logic ld_ready;
    logic ld_data;
    logic ld_last;
    logic ld_par;
    logic addr;
    logic data;
    logic cpu_n_rst;
    logic loaded;
    logic par_err;

    int total = 0;
    int bad   = 0;

    prog_loader_mem #(.ADDR_W(1), .DATA_W(1)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_data   (ld_data),
        .ld_last   (ld_last),
        .ld_par    (ld_par),
        .addr      (addr),
        .data      (data),
        .cpu_n_rst (cpu_n_rst),
        .loaded    (loaded),
        .par_err   (par_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic observed, input logic expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic d, input logic last, input logic par);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        ld_par   = par;
        tick();
        ld_valid = 1'b0;
        ld_data  = 1'b0;
        ld_last  = 1'b0;
        ld_par   = 1'b0;
    endtask

    task automatic pulse_reset();
        n_rst = 1'b0;
        #2;
        n_rst = 1'b1;
        #1;
    endtask

    task automatic read(input string tag, input logic a, input logic expected);
        addr = a;
        #1;
        chk(tag, data, expected);
    endtask

    initial begin
        n_rst    = 1'b0;
        ld_valid = 1'b0;
        ld_data  = 1'b0;
        ld_last  = 1'b0;
        ld_par   = 1'b0;
        addr     = 1'b0;

        // 1: reset state
        #1;
        chk("rst_cpu_n_rst", cpu_n_rst, 1'b0);
        chk("rst_loaded", loaded, 1'b0);
        chk("rst_par_err", par_err, 1'b0);
        tick();
        tick();
        n_rst = 1'b1;
        tick();
        chk("idle_ld_ready", ld_ready, 1'b1);
        chk("idle_cpu_n_rst", cpu_n_rst, 1'b0);
        chk("idle_loaded", loaded, 1'b0);
        chk("idle_par_err", par_err, 1'b0);
        read("idle_data0", 1'b0, 1'b0);
        read("idle_data1", 1'b1, 1'b0);

        // 2: two beats with a gap, release one edge after the last accept
        beat(1'b1, 1'b0, 1'b0);
        chk("t2_ready_mid", ld_ready, 1'b1);
        tick();
        chk("t2_ready_gap", ld_ready, 1'b1);
        chk("t2_loaded_gap", loaded, 1'b0);
        beat(1'b0, 1'b1, 1'b1);
        chk("t2_ready_after", ld_ready, 1'b0);
        chk("t2_cpu_rst_rel", cpu_n_rst, 1'b0);
        chk("t2_loaded_rel", loaded, 1'b0);
        read("t2_data_rel", 1'b0, 1'b0);
        tick();
        chk("t2_cpu_rst_run", cpu_n_rst, 1'b1);
        chk("t2_loaded_run", loaded, 1'b1);
        read("t2_data0", 1'b0, 1'b1);
        read("t2_data1", 1'b1, 1'b0);

        // 4: buffer-full completion without ld_last, later beats ignored
        pulse_reset();
        chk("t4_cpu_rst_after_rst", cpu_n_rst, 1'b0);
        read("t4_data_after_rst", 1'b0, 1'b0);
        beat(1'b1, 1'b0, 1'b0);
        beat(1'b1, 1'b0, 1'b0);
        chk("t4_ready_full", ld_ready, 1'b0);
        tick();
        chk("t4_loaded", loaded, 1'b1);
        ld_valid = 1'b1;
        ld_data  = 1'b0;
        ld_last  = 1'b1;
        tick();
        tick();
        chk("t4_ready_run", ld_ready, 1'b0);
        read("t4_data0", 1'b0, 1'b1);
        read("t4_data1", 1'b1, 1'b1);
        ld_valid = 1'b0;
        ld_last  = 1'b0;

        // 3: single beat after reset; untouched entry must read as cleared
        pulse_reset();
        beat(1'b1, 1'b1, 1'b1);
        tick();
        chk("t3_loaded", loaded, 1'b1);
        chk("t3_cpu_rst", cpu_n_rst, 1'b1);
        read("t3_data0", 1'b0, 1'b1);
        read("t3_data1", 1'b1, 1'b0);

        // 5: reset mid-load restarts from address 0
        pulse_reset();
        beat(1'b1, 1'b0, 1'b0);
        n_rst = 1'b0;
        #1;
        chk("t5_cpu_rst_in_rst", cpu_n_rst, 1'b0);
        n_rst = 1'b1;
        #1;
        chk("t5_ready_restart", ld_ready, 1'b1);
        beat(1'b0, 1'b0, 1'b0);
        beat(1'b1, 1'b1, 1'b1);
        tick();
        chk("t5_loaded", loaded, 1'b1);
        read("t5_data0", 1'b0, 1'b0);
        read("t5_data1", 1'b1, 1'b1);

`ifdef LOADER_PARITY_EN
        // 6: parity mismatch goes to ERR, match runs
        pulse_reset();
        beat(1'b1, 1'b0, 1'b0);
        beat(1'b1, 1'b1, 1'b1);
        chk("t6_par_err", par_err, 1'b1);
        chk("t6_ready_err", ld_ready, 1'b0);
        tick();
        chk("t6_par_err_hold", par_err, 1'b1);
        chk("t6_cpu_rst_err", cpu_n_rst, 1'b0);
        chk("t6_loaded_err", loaded, 1'b0);
        read("t6_data_err", 1'b0, 1'b0);
        pulse_reset();
        chk("t6_par_err_clr", par_err, 1'b0);
        beat(1'b1, 1'b0, 1'b0);
        beat(1'b1, 1'b1, 1'b0);
        tick();
        chk("t6_loaded_ok", loaded, 1'b1);
        chk("t6_par_err_ok", par_err, 1'b0);
        read("t6_data_ok", 1'b1, 1'b1);
`else
        // 6: without the parity option ld_par is ignored
        pulse_reset();
        beat(1'b1, 1'b0, 1'b0);
        beat(1'b1, 1'b1, 1'b1);
        tick();
        chk("t6_loaded_nopar", loaded, 1'b1);
        chk("t6_par_err_nopar", par_err, 1'b0);
        read("t6_data_nopar", 1'b0, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
